// File: rtl/matmul_seq_ctrl.sv
// Address/strobe sequencer for a single-MAC matrix multiply C = A x B.
// Optional cycle counter on perf_cycles when SEQ_PERF_CNT_EN is defined.
module matmul_seq_ctrl #(
    parameter int ADDR_W  = 16,
    parameter int DIM_W   = 16,
    parameter int MAC_LAT = 1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              dut_valid,
    output logic              dut_ready,
    output logic [ADDR_W-1:0] in_rd_addr,
    input  logic [31:0]       in_rd_data,
    output logic [ADDR_W-1:0] wt_rd_addr,
    input  logic [31:0]       wt_rd_data,
    output logic              op_valid,
    output logic              op_first,
    output logic              op_last,
    output logic              res_wr_en,
    output logic [ADDR_W-1:0] res_wr_addr,
    output logic [31:0]       perf_cycles
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_RD_DIM = 3'd1;
    localparam logic [2:0] S_LD_DIM = 3'd2;
    localparam logic [2:0] S_STREAM = 3'd3;
    localparam logic [2:0] S_DRAIN  = 3'd4;
    localparam logic [2:0] S_DONE   = 3'd5;

    localparam logic [DIM_W-1:0]  DIM_ONE  = 1;
    localparam logic [ADDR_W-1:0] ADDR_ONE = 1;

    logic [2:0]        state_q, state_d;
    logic              dut_ready_q;
    logic [DIM_W-1:0]  m_dim_q, k_dim_q, n_dim_q;
    logic [DIM_W-1:0]  m_dim_d, k_dim_d, n_dim_d;
    logic [DIM_W-1:0]  i_q, j_q, k_q, i_d, j_d, k_d;
    logic [ADDR_W-1:0] in_row_base_q, in_row_base_d;
    logic [ADDR_W-1:0] wt_col_base_q, wt_col_base_d;
    logic [ADDR_W-1:0] in_addr_q, in_addr_d, wt_addr_q, wt_addr_d;
    logic              op_valid_q, op_first_q, op_last_q, res_wr_en_q;
    logic [ADDR_W-1:0] res_addr_q;
    logic [MAC_LAT-1:0] last_pipe_q;

    logic              start;
    logic              k_wrap, j_wrap, i_wrap, pending;
    logic [ADDR_W-1:0] k_step;
    logic              wt_k_unused;

    // The weight word repeats K; the input word's copy is authoritative.
    assign wt_k_unused = ^wt_rd_data[31:16];

    assign start   = (state_q == S_IDLE) && dut_valid;
    assign k_wrap  = (k_q == k_dim_q - DIM_ONE);
    assign j_wrap  = (j_q == n_dim_q - DIM_ONE);
    assign i_wrap  = (i_q == m_dim_q - DIM_ONE);
    assign k_step  = ADDR_W'(k_dim_q);
    assign pending = op_last_q | (|last_pipe_q);

    always_comb begin
        state_d       = state_q;
        m_dim_d       = m_dim_q;
        k_dim_d       = k_dim_q;
        n_dim_d       = n_dim_q;
        i_d           = i_q;
        j_d           = j_q;
        k_d           = k_q;
        in_row_base_d = in_row_base_q;
        wt_col_base_d = wt_col_base_q;
        in_addr_d     = in_addr_q;
        wt_addr_d     = wt_addr_q;
        case (state_q)
            S_IDLE: begin
                in_addr_d = '0;
                wt_addr_d = '0;
                if (dut_valid) state_d = S_RD_DIM;
            end
            S_RD_DIM: state_d = S_LD_DIM;
            S_LD_DIM: begin
                m_dim_d = in_rd_data[31:16];
                k_dim_d = in_rd_data[15:0];
                n_dim_d = wt_rd_data[15:0];
                if (in_rd_data[31:16] == '0 || in_rd_data[15:0] == '0 || wt_rd_data[15:0] == '0) begin
                    state_d = S_DONE;
                end else begin
                    state_d       = S_STREAM;
                    i_d           = '0;
                    j_d           = '0;
                    k_d           = '0;
                    in_row_base_d = ADDR_ONE;
                    wt_col_base_d = ADDR_ONE;
                    in_addr_d     = ADDR_ONE;
                    wt_addr_d     = ADDR_ONE;
                end
            end
            S_STREAM: begin
                if (!k_wrap) begin
                    k_d       = k_q + DIM_ONE;
                    in_addr_d = in_addr_q + ADDR_ONE;
                    wt_addr_d = wt_addr_q + ADDR_ONE;
                end else begin
                    k_d = '0;
                    if (!j_wrap) begin
                        j_d           = j_q + DIM_ONE;
                        wt_col_base_d = wt_col_base_q + k_step;
                        wt_addr_d     = wt_col_base_q + k_step;
                        in_addr_d     = in_row_base_q;
                    end else if (!i_wrap) begin
                        j_d           = '0;
                        i_d           = i_q + DIM_ONE;
                        in_row_base_d = in_row_base_q + k_step;
                        in_addr_d     = in_row_base_q + k_step;
                        wt_col_base_d = ADDR_ONE;
                        wt_addr_d     = ADDR_ONE;
                    end else begin
                        j_d       = '0;
                        state_d   = S_DRAIN;
                        in_addr_d = '0;
                        wt_addr_d = '0;
                    end
                end
            end
            // Leave once the final write strobe is on the output this cycle.
            S_DRAIN: if (!pending) state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= S_IDLE;
            dut_ready_q   <= 1'b0;
            m_dim_q       <= '0;
            k_dim_q       <= '0;
            n_dim_q       <= '0;
            i_q           <= '0;
            j_q           <= '0;
            k_q           <= '0;
            in_row_base_q <= '0;
            wt_col_base_q <= '0;
            in_addr_q     <= '0;
            wt_addr_q     <= '0;
            op_valid_q    <= 1'b0;
            op_first_q    <= 1'b0;
            op_last_q     <= 1'b0;
            res_wr_en_q   <= 1'b0;
            res_addr_q    <= '0;
        end else begin
            state_q       <= state_d;
            dut_ready_q   <= (state_d == S_IDLE);
            m_dim_q       <= m_dim_d;
            k_dim_q       <= k_dim_d;
            n_dim_q       <= n_dim_d;
            i_q           <= i_d;
            j_q           <= j_d;
            k_q           <= k_d;
            in_row_base_q <= in_row_base_d;
            wt_col_base_q <= wt_col_base_d;
            in_addr_q     <= in_addr_d;
            wt_addr_q     <= wt_addr_d;
            op_valid_q    <= (state_q == S_STREAM);
            op_first_q    <= (state_q == S_STREAM) && (k_q == '0);
            op_last_q     <= (state_q == S_STREAM) && k_wrap;
            res_wr_en_q   <= last_pipe_q[MAC_LAT-1];
            if (start)            res_addr_q <= '0;
            else if (res_wr_en_q) res_addr_q <= res_addr_q + ADDR_ONE;
        end
    end

    // op_last delayed MAC_LAT cycles; one more register stage forms res_wr_en.
    generate
        for (genvar gi = 0; gi < MAC_LAT; gi++) begin : g_last_pipe
            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    last_pipe_q[gi] <= 1'b0;
                end else begin
                    if (gi == 0) last_pipe_q[gi] <= op_last_q;
                    else         last_pipe_q[gi] <= last_pipe_q[(gi > 0) ? gi - 1 : 0];
                end
            end
        end
    endgenerate

`ifdef SEQ_PERF_CNT_EN
    logic [31:0] perf_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            perf_q <= '0;
        end else if (state_q == S_IDLE) begin
            if (dut_valid) perf_q <= '0;
        end else if (perf_q != 32'hFFFF_FFFF) begin
            perf_q <= perf_q + 32'd1;
        end
    end

    assign perf_cycles = perf_q;
`else
    assign perf_cycles = '0;
`endif

    assign dut_ready   = dut_ready_q;
    assign in_rd_addr  = in_addr_q;
    assign wt_rd_addr  = wt_addr_q;
    assign op_valid    = op_valid_q;
    assign op_first    = op_first_q;
    assign op_last     = op_last_q;
    assign res_wr_en   = res_wr_en_q;
    assign res_wr_addr = res_addr_q;

endmodule
